// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared codes and types for the fetch/decode sequencer
//
// Purpose: bus source select codes, the sequencer state encoding, the
//          register/IO opcode value and a small one-hot helper.
// Ports:   none (package).

package fetch_sequencer_pkg;

  typedef logic [2:0] bus_sel_t;

  // Bus source codes; SEL_NONE leaves the shared bus undriven.
  localparam bus_sel_t SEL_NONE = 3'd0;
  localparam bus_sel_t SEL_AR   = 3'd1;
  localparam bus_sel_t SEL_PC   = 3'd2;
  localparam bus_sel_t SEL_DR   = 3'd3;
  localparam bus_sel_t SEL_AC   = 3'd4;
  localparam bus_sel_t SEL_IR   = 3'd5;
  localparam bus_sel_t SEL_TR   = 3'd6;
  localparam bus_sel_t SEL_MEM  = 3'd7;

  // Opcode 7 is the register-reference / IO class: ir[15] there is not an
  // indirect flag, so it never takes the T3 indirect cycle.
  localparam logic [2:0] OPC_REG_IO = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_EXEC = 3'd5
  } state_t;

  function automatic logic [7:0] onehot3(input logic [2:0] v);
    logic [7:0] r;
    r = 8'd0;
    r[v] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - bus control and execute handshake bundle
//
// Purpose: groups the shared-bus select, destination load strobes and the
//          execute-unit req/done handshake driven by the sequencer.
// Ports (master = sequencer side):
//   bus_sel   out  bus source code, SEL_NONE when undriven
//   ld_ar     out  load AR from bus
//   ld_ir     out  load IR from bus
//   inr_pc    out  increment PC
//   mem_rd    out  memory read, meaningful with bus_sel = SEL_MEM
//   exec_req  out  execute phase active
//   exec_done in   execute unit finished the current instruction

interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  bus_sel_t bus_sel;
  logic     ld_ar;
  logic     ld_ir;
  logic     inr_pc;
  logic     mem_rd;
  logic     exec_req;
  logic     exec_done;

  modport master (
    output bus_sel,
    output ld_ar,
    output ld_ir,
    output inr_pc,
    output mem_rd,
    output exec_req,
    input  exec_done
  );

  modport slave (
    input  bus_sel,
    input  ld_ar,
    input  ld_ir,
    input  inr_pc,
    input  mem_rd,
    input  exec_req,
    output exec_done
  );

endinterface

// File: rtl/fetch_sequencer_opcode_decoder.sv
// rtl/fetch_sequencer_opcode_decoder.sv - 3-to-8 one-hot opcode decoder
//
// Purpose: combinational decode of the IR opcode field to a one-hot vector.
// Ports:
//   opcode  in   3  ir[14:12]
//   onehot  out  8  bit n set when opcode == n

module opcode_decoder_3to8
  import fetch_sequencer_pkg::*;
(
  input  logic [2:0] opcode,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = onehot3(opcode);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/decode/indirect timing sequencer with execute handoff
//
// Purpose: steps T0..T3 of the basic computer, drives the bus select and the
//          AR/IR/PC strobes, latches the opcode decode and hands off to the
//          execute unit. Owns timing counter SC and the run flip-flop S.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   start      pulse; sets S from IDLE
//   halt       pulse; stops after the current instruction
//   ir         current IR contents
//   bus        fetch_sequencer_if.master: bus_sel, strobes, exec_req/exec_done
//   d, i_bit   one-hot opcode and indirect bit, captured in T2
//   sc         timing counter
//   running    S flip-flop
//   fault      sticky execute timeout

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int SC_W     = 4,
  parameter int EXEC_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                halt,
  input  logic [15:0]         ir,
  fetch_sequencer_if.master   bus,
  output logic [7:0]          d,
  output logic                i_bit,
  output logic [SC_W-1:0]     sc,
  output logic                running,
  output logic                fault
);

  localparam logic [SC_W-1:0] SC_ZERO = '0;
  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
  localparam logic [SC_W-1:0] SC_T1   = SC_W'(1);
  localparam logic [SC_W-1:0] SC_T2   = SC_W'(2);
  localparam logic [SC_W-1:0] SC_T3   = SC_W'(3);
  localparam logic [SC_W-1:0] SC_EX4  = SC_W'(4);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(EXEC_MAX);

  state_t           state_q, state_d;
  logic [SC_W-1:0]  sc_d;
  logic             run_d;
  logic             halt_pend_q, halt_pend_d;
  logic             fault_d;
  logic             cap_decode;
  logic [7:0]       dec_onehot;
  logic             is_indirect;
  logic             halt_any;

  // AR picks up ir[11:0] straight off the bus in T2; the sequencer itself
  // only looks at the opcode and I bit.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[11:0];

  opcode_decoder_3to8 u_dec (
    .opcode (ir[14:12]),
    .onehot (dec_onehot)
  );

  // Opcode 7 reuses ir[15] as a class bit, so only memory-reference
  // instructions with I=1 take the indirect cycle.
  assign is_indirect = ir[15] && (ir[14:12] != OPC_REG_IO);
  assign halt_any    = halt || halt_pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sc          <= SC_ZERO;
      running     <= 1'b0;
      halt_pend_q <= 1'b0;
      fault       <= 1'b0;
      d           <= 8'd0;
      i_bit       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc          <= sc_d;
      running     <= run_d;
      halt_pend_q <= halt_pend_d;
      fault       <= fault_d;
      if (cap_decode) begin
        d     <= dec_onehot;
        i_bit <= ir[15];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sc_d        = sc;
    run_d       = running;
    fault_d     = fault;
    cap_decode  = 1'b0;
    halt_pend_d = halt_pend_q;
    // A halt anywhere in an instruction is remembered until S is dropped.
    if (halt && (state_q != ST_IDLE)) begin
      halt_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        halt_pend_d = 1'b0;
        // halt beats start when both arrive together
        if (start && !halt) begin
          run_d   = 1'b1;
          state_d = ST_T0;
          sc_d    = SC_ZERO;
        end
      end

      ST_T0: begin
        // Fetch boundary: S drops here, but the instruction just started
        // still runs to completion and then parks in IDLE.
        if (halt_any) begin
          run_d       = 1'b0;
          halt_pend_d = 1'b0;
        end
        state_d = ST_T1;
        sc_d    = SC_T1;
      end

      ST_T1: begin
        state_d = ST_T2;
        sc_d    = SC_T2;
      end

      ST_T2: begin
        cap_decode = 1'b1;
        state_d    = is_indirect ? ST_T3 : ST_EXEC;
        sc_d       = SC_T3;
      end

      ST_T3: begin
        state_d = ST_EXEC;
        sc_d    = SC_EX4;
      end

      ST_EXEC: begin
        if (bus.exec_done) begin
          sc_d = SC_ZERO;
          if (running && !halt_any) begin
            state_d = ST_T0;
          end else begin
            state_d     = ST_IDLE;
            run_d       = 1'b0;
            halt_pend_d = 1'b0;
          end
        end else if (sc == SC_MAX) begin
          // Execute unit never answered: park with sc frozen at the limit.
          fault_d     = 1'b1;
          run_d       = 1'b0;
          halt_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          sc_d = sc + SC_ONE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        sc_d        = SC_ZERO;
        run_d       = 1'b0;
        halt_pend_d = 1'b0;
      end
    endcase
  end

  // Moore strobes, decoded from the current state only.
  always_comb begin
    bus.bus_sel  = SEL_NONE;
    bus.ld_ar    = 1'b0;
    bus.ld_ir    = 1'b0;
    bus.inr_pc   = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.exec_req = 1'b0;
    case (state_q)
      ST_T0: begin
        bus.bus_sel = SEL_PC;
        bus.ld_ar   = 1'b1;
      end
      ST_T1: begin
        bus.bus_sel = SEL_MEM;
        bus.mem_rd  = 1'b1;
        bus.ld_ir   = 1'b1;
        bus.inr_pc  = 1'b1;
      end
      ST_T2: begin
        bus.bus_sel = SEL_IR;
        bus.ld_ar   = 1'b1;
      end
      ST_T3: begin
        bus.bus_sel = SEL_MEM;
        bus.mem_rd  = 1'b1;
        bus.ld_ar   = 1'b1;
      end
      ST_EXEC: begin
        bus.exec_req = 1'b1;
      end
      default: begin
        bus.bus_sel = SEL_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer

module tb_fetch_sequencer;

  typedef enum int {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_EXEC} st_e;

  typedef struct packed {
    logic [2:0] bus_sel;
    logic       ld_ar;
    logic       ld_ir;
    logic       inr_pc;
    logic       mem_rd;
    logic       exec_req;
    logic [3:0] sc;
    logic       running;
    logic       fault;
    logic [7:0] d;
    logic       i_bit;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt;
  logic [15:0] ir;
  logic [7:0]  d;
  logic        i_bit;
  logic [3:0]  sc;
  logic        running;
  logic        fault;

  fetch_sequencer_if bus_if ();

  fetch_sequencer #(.SC_W(4), .EXEC_MAX(15)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .halt    (halt),
    .ir      (ir),
    .bus     (bus_if),
    .d       (d),
    .i_bit   (i_bit),
    .sc      (sc),
    .running (running),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  obs_t  exp_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  // Expected strobes for each state, written from the bus cycle table.
  function automatic obs_t mk(input st_e s, input int scv, input logic run,
                              input logic flt, input logic [7:0] dv, input logic iv);
    obs_t e;
    e = '0;
    case (s)
      S_T0:   begin e.bus_sel = 3'd2; e.ld_ar = 1'b1; end
      S_T1:   begin e.bus_sel = 3'd7; e.mem_rd = 1'b1; e.ld_ir = 1'b1; e.inr_pc = 1'b1; end
      S_T2:   begin e.bus_sel = 3'd5; e.ld_ar = 1'b1; end
      S_T3:   begin e.bus_sel = 3'd7; e.mem_rd = 1'b1; e.ld_ar = 1'b1; end
      S_EXEC: begin e.exec_req = 1'b1; end
      default: e.bus_sel = 3'd0;
    endcase
    e.sc      = 4'(scv);
    e.running = run;
    e.fault   = flt;
    e.d       = dv;
    e.i_bit   = iv;
    return e;
  endfunction

  task automatic check_one();
    obs_t  e;
    obs_t  a;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    a = {bus_if.bus_sel, bus_if.ld_ar, bus_if.ld_ir, bus_if.inr_pc, bus_if.mem_rd,
         bus_if.exec_req, sc, running, fault, d, i_bit};
    tests++;
    assert (a === e) else begin
      fails++;
      $error("FAIL %s: observed sel=%0d ar=%b ir=%b pc=%b rd=%b req=%b sc=%0d run=%b flt=%b d=%h i=%b expected sel=%0d ar=%b ir=%b pc=%b rd=%b req=%b sc=%0d run=%b flt=%b d=%h i=%b",
             t, a.bus_sel, a.ld_ar, a.ld_ir, a.inr_pc, a.mem_rd, a.exec_req, a.sc, a.running, a.fault, a.d, a.i_bit,
             e.bus_sel, e.ld_ar, e.ld_ir, e.inr_pc, e.mem_rd, e.exec_req, e.sc, e.running, e.fault, e.d, e.i_bit);
    end
  endtask

  // Push the expectation for the state after the coming edge, then sample.
  task automatic cyc(input obs_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    check_one();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; ir = 16'h0000; bus_if.exec_done = 1'b0;
    cyc(mk(S_IDLE, 0, 0, 0, 8'h00, 0), "reset");
    cyc(mk(S_IDLE, 0, 0, 0, 8'h00, 0), "reset_hold");
    rst = 1'b0;

    // Direct memory-reference instruction, done in the 2nd EXEC cycle
    ir = 16'h2005; start = 1'b1;
    cyc(mk(S_T0, 0, 1, 0, 8'h00, 0), "a_t0");
    start = 1'b0;
    cyc(mk(S_T1, 1, 1, 0, 8'h00, 0), "a_t1");
    cyc(mk(S_T2, 2, 1, 0, 8'h00, 0), "a_t2");
    cyc(mk(S_EXEC, 3, 1, 0, 8'h04, 0), "a_exec3");
    cyc(mk(S_EXEC, 4, 1, 0, 8'h04, 0), "a_exec4");
    bus_if.exec_done = 1'b1;
    cyc(mk(S_T0, 0, 1, 0, 8'h04, 0), "a_next_t0");
    bus_if.exec_done = 1'b0;

    // Indirect instruction takes T3
    ir = 16'hA123;
    cyc(mk(S_T1, 1, 1, 0, 8'h04, 0), "b_t1");
    cyc(mk(S_T2, 2, 1, 0, 8'h04, 0), "b_t2");
    cyc(mk(S_T3, 3, 1, 0, 8'h04, 1), "b_t3");
    cyc(mk(S_EXEC, 4, 1, 0, 8'h04, 1), "b_exec4");
    bus_if.exec_done = 1'b1;
    cyc(mk(S_T0, 0, 1, 0, 8'h04, 1), "b_next_t0");
    bus_if.exec_done = 1'b0;

    // Opcode 7 with I=1 skips T3
    ir = 16'hF800;
    cyc(mk(S_T1, 1, 1, 0, 8'h04, 1), "c_t1");
    cyc(mk(S_T2, 2, 1, 0, 8'h04, 1), "c_t2");
    cyc(mk(S_EXEC, 3, 1, 0, 8'h80, 1), "c_exec3");
    bus_if.exec_done = 1'b1;
    cyc(mk(S_T0, 0, 1, 0, 8'h80, 1), "c_next_t0");
    bus_if.exec_done = 1'b0;

    // halt during EXEC: instruction finishes, then IDLE
    ir = 16'h2005;
    cyc(mk(S_T1, 1, 1, 0, 8'h80, 1), "h_t1");
    cyc(mk(S_T2, 2, 1, 0, 8'h80, 1), "h_t2");
    cyc(mk(S_EXEC, 3, 1, 0, 8'h04, 0), "h_exec3");
    halt = 1'b1;
    cyc(mk(S_EXEC, 4, 1, 0, 8'h04, 0), "h_exec4");
    halt = 1'b0;
    cyc(mk(S_EXEC, 5, 1, 0, 8'h04, 0), "h_exec5");
    bus_if.exec_done = 1'b1;
    cyc(mk(S_IDLE, 0, 0, 0, 8'h04, 0), "h_idle");
    cyc(mk(S_IDLE, 0, 0, 0, 8'h04, 0), "h_no_t0");
    cyc(mk(S_IDLE, 0, 0, 0, 8'h04, 0), "done_in_idle_ignored");
    bus_if.exec_done = 1'b0;

    // Execute timeout; a start pulse while running is ignored
    start = 1'b1;
    cyc(mk(S_T0, 0, 1, 0, 8'h04, 0), "t_t0");
    start = 1'b0;
    cyc(mk(S_T1, 1, 1, 0, 8'h04, 0), "t_t1");
    cyc(mk(S_T2, 2, 1, 0, 8'h04, 0), "t_t2");
    cyc(mk(S_EXEC, 3, 1, 0, 8'h04, 0), "t_exec3");
    for (int k = 4; k <= 15; k++) begin
      start = (k == 6);
      cyc(mk(S_EXEC, k, 1, 0, 8'h04, 0), $sformatf("t_exec%0d", k));
    end
    start = 1'b0;
    cyc(mk(S_IDLE, 15, 0, 1, 8'h04, 0), "t_fault");
    cyc(mk(S_IDLE, 15, 0, 1, 8'h04, 0), "t_sc_hold");

    // fault is sticky across a new run; rst in T1 clears everything
    start = 1'b1;
    cyc(mk(S_T0, 0, 1, 1, 8'h04, 0), "f_t0");
    start = 1'b0;
    cyc(mk(S_T1, 1, 1, 1, 8'h04, 0), "f_t1");
    rst = 1'b1;
    cyc(mk(S_IDLE, 0, 0, 0, 8'h00, 0), "rst_in_t1");
    rst = 1'b0;

    // start with halt in the same cycle: halt wins
    start = 1'b1; halt = 1'b1;
    cyc(mk(S_IDLE, 0, 0, 0, 8'h00, 0), "start_halt_same");
    start = 1'b0; halt = 1'b0;
    cyc(mk(S_IDLE, 0, 0, 0, 8'h00, 0), "stay_idle");

    // halt seen in IDLE left no pending stop behind
    start = 1'b1;
    cyc(mk(S_T0, 0, 1, 0, 8'h00, 0), "restart_t0");
    start = 1'b0;
    cyc(mk(S_T1, 1, 1, 0, 8'h00, 0), "restart_t1_running");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
